dadda_dot_accum: RTL and testbench
==================================

# dadda_dot_accum

Streaming dot-product accumulator that sits directly downstream of the pipelined `dadda_mult` multiplier. It consumes each `product`/`valid_out` pair and sums a programmed number of products into a wide accumulator. It then emits one registered result per vector, with a sticky overflow indication. It turns the multiplier into a MAC/dot-product engine without adding any backpressure on the multiplier.

## Interface
- `WIDTH`, default 16: multiplier operand width; product input is 2*WIDTH bits.
- `ACC_WIDTH`, default 40: accumulator and result width; must be ≥ 2*WIDTH.
- `SATURATE`, default 1: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a new vector; latches `vec_len`.
- `vec_len`, input, 8: number of products in the vector, 0–255; sampled only when `start`=1.
- `product`, input, 2*WIDTH: unsigned product; connects to multiplier `product`.
- `valid_in`, input, 1: `product` is valid this cycle; connects to multiplier `valid_out`.
- `sum`, output, ACC_WIDTH: last completed dot product; held until the next result.
- `valid_out`, output, 1: one-cycle pulse when `sum` and `overflow` update.
- `overflow`, output, 1: the vector reported with `sum` overflowed ACC_WIDTH.
- `busy`, output, 1: 1 while in ACCUM.
- `drop`, output, 1: one-cycle pulse when a valid product was discarded.

## Operation
- **States:** IDLE and ACCUM. Internal registers:
  - `acc` (ACC_WIDTH)
  - `cnt` (8)
  - `len` (8)
  - `ovf` (sticky, per vector)
- **Addition:** `product` is zero-extended to ACC_WIDTH. Overflow is the carry out of the ACC_WIDTH add. On overflow, `ovf` sets.
  - SATURATE=1: `acc` becomes all-ones and stays all-ones for the rest of the vector.
  - SATURATE=0: `acc` keeps the wrapped value.
- **IDLE:**
  - `start`=1 and `vec_len`=0: no accumulation. Next cycle `sum`=0, `overflow`=0, `valid_out`=1. Stay in IDLE. A coincident `valid_in` pulses `drop`.
  - `start`=1 and `vec_len`≥1: load `len`, set `ovf`=0, go to ACCUM.
    - With coincident `valid_in`: `acc`=product and `cnt`=1. If `vec_len`=1, complete immediately (see completion).
    - Without `valid_in`: `acc`=0 and `cnt`=0.
  - `valid_in`=1 without `start`: product discarded; `drop` pulses next cycle.
- **ACCUM:** each `valid_in` adds `product` to `acc` and increments `cnt`. Gaps in `valid_in` of any length are allowed.
- **Completion:** the cycle that accepts product number `len`. Next edge: `sum` gets the final acc value, `overflow` gets the final `ovf`, `valid_out`=1, state returns to IDLE.
- **`start` in ACCUM:** start has priority over everything, including a completing product. The partial vector is discarded with no `valid_out`, and a new vector begins as in IDLE (coincident `valid_in` counts as element 0).
- **Completion into IDLE:** a `start` in the cycle after completion is accepted normally, so back-to-back vectors have no dead cycle.

## Timing
- **Reset values:** `sum`=0, `overflow`=0, `valid_out`=0, `busy`=0, `drop`=0; state IDLE; `acc`/`cnt`/`len`/`ovf`=0.
- **Reset mid-vector:** the partial vector is lost and no `valid_out` is produced.
- **Latency:** `valid_out` asserts exactly 1 cycle after the edge that accepts the final product.
- **`vec_len`=0:** `valid_out` asserts 1 cycle after `start`.
- **Outputs:** all outputs are registered; none depends combinationally on the inputs.
- **`busy`:** rises the cycle after `start` (with `vec_len`≥1) and falls in the same cycle `valid_out` rises.
- **Result hold:** `sum` and `overflow` change only on `valid_out` cycles or reset.
- **Throughput:** one product per cycle is sustained; no input is ever stalled.

## Test plan
- **Basic sum:** WIDTH=16, ACC_WIDTH=40; `start` with `vec_len`=4; products 1,2,3,4 on consecutive cycles. Expect `sum`=10 and `overflow`=0, with `valid_out` exactly 1 cycle after the 4th product. `busy` is high for 4 cycles.
- **Gapped input:** `vec_len`=3; product 0xFFFE0001 (65535×65535) ×3, with 0–5 idle cycles between. Expect `sum`=0x2FFFA0003 and a single `valid_out`.
- **Overflow:** ACC_WIDTH=32, `vec_len`=2, products 0xFFFE0001 ×2.
  - SATURATE=1: `sum`=0xFFFFFFFF, `overflow`=1.
  - SATURATE=0: `sum`=0xFFFC0002, `overflow`=1.
  - Next clean vector reports `overflow`=0.
- **Restart:** `vec_len`=4, products 7,9, then `start` with `vec_len`=2 and coincident product 5, then 6. Expect one `valid_out` with `sum`=11; no result for the aborted vector.
- **Edge cases:**
  - `vec_len`=0: `sum`=0 and `valid_out` 1 cycle later.
  - `valid_in` in IDLE without `start`: `drop` pulses once; `sum` unchanged.
  - `vec_len`=1 with coincident product 0x8000×0x8000: `sum`=0x40000000.
- **Reset:** `rst` asserted after 2 of 4 products. All outputs read 0 on the next cycle; a following vector 2,3 with `vec_len`=2 gives `sum`=5.

Source files
------------

// File: rtl/dadda_dot_accum.sv
// Streaming dot-product accumulator fed by the dadda_mult product stream.
// Sums vec_len products per vector; emits a registered sum with sticky overflow.
module dadda_dot_accum #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [7:0]           vec_len_i,
  input  logic [2*WIDTH-1:0]   product_i,
  input  logic                 valid_in_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 valid_out_o,
  output logic                 overflow_o,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_ACCUM = 1'b1;

  logic                 state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           len_q, len_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 vo_q, vo_d;
  logic                 ovfo_q, ovfo_d;
  logic                 drop_q, drop_d;

  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   add_full;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_add;
  logic [7:0]           cnt_inc;
  logic                 last;

  assign prod_ext = ACC_WIDTH'(product_i);
  assign add_full = {1'b0, acc_q} + {1'b0, prod_ext};
  assign carry    = add_full[ACC_WIDTH];
  // Once clamped, acc is all-ones; any further nonzero add carries again, so it stays clamped.
  assign acc_add  = (SATURATE && carry) ? '1 : add_full[ACC_WIDTH-1:0];
  assign cnt_inc  = cnt_q + 8'd1;
  assign last     = (cnt_inc == len_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    ovfo_d  = ovfo_q;
    vo_d    = 1'b0;
    drop_d  = 1'b0;
    if (start_i) begin
      // start wins over a completing product; the partial vector is simply dropped
      len_d = vec_len_i;
      ovf_d = 1'b0;
      cnt_d = {7'd0, valid_in_i};
      acc_d = valid_in_i ? prod_ext : '0;
      if (vec_len_i == 8'd0) begin
        state_d = S_IDLE;
        sum_d   = '0;
        ovfo_d  = 1'b0;
        vo_d    = 1'b1;
        drop_d  = valid_in_i;
      end else if (vec_len_i == 8'd1 && valid_in_i) begin
        state_d = S_IDLE;
        sum_d   = prod_ext;
        ovfo_d  = 1'b0;
        vo_d    = 1'b1;
      end else begin
        state_d = S_ACCUM;
      end
    end else if (valid_in_i) begin
      if (state_q == S_ACCUM) begin
        acc_d = acc_add;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | carry;
        if (last) begin
          state_d = S_IDLE;
          sum_d   = acc_add;
          ovfo_d  = ovf_q | carry;
          vo_d    = 1'b1;
        end
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      vo_q    <= 1'b0;
      ovfo_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      vo_q    <= vo_d;
      ovfo_q  <= ovfo_d;
      drop_q  <= drop_d;
    end
  end

  assign sum_o       = sum_q;
  assign valid_out_o = vo_q;
  assign overflow_o  = ovfo_q;
  assign busy_o      = (state_q == S_ACCUM);
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_dadda_dot_accum.sv
// Bench for dadda_dot_accum: three configurations share one stimulus stream and are
// checked against a vector-level model that keeps the exact running total as an integer.
module tb_dadda_dot_accum;

  logic        clk = 1'b0;
  logic        rst, start, valid_in;
  logic [7:0]  vec_len;
  logic [31:0] product;

  logic [39:0] sum40;
  logic [31:0] sum32s, sum32w;
  logic [2:0]  vo, ovf, busy, drp;

  always #5 clk = ~clk;

  dadda_dot_accum #(.WIDTH(16), .ACC_WIDTH(40), .SATURATE(1'b1)) u_d40s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vec_len_i(vec_len), .product_i(product),
    .valid_in_i(valid_in), .sum_o(sum40), .valid_out_o(vo[0]), .overflow_o(ovf[0]),
    .busy_o(busy[0]), .drop_o(drp[0]));

  dadda_dot_accum #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b1)) u_d32s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vec_len_i(vec_len), .product_i(product),
    .valid_in_i(valid_in), .sum_o(sum32s), .valid_out_o(vo[1]), .overflow_o(ovf[1]),
    .busy_o(busy[1]), .drop_o(drp[1]));

  dadda_dot_accum #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b0)) u_d32w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vec_len_i(vec_len), .product_i(product),
    .valid_in_i(valid_in), .sum_o(sum32w), .valid_out_o(vo[2]), .overflow_o(ovf[2]),
    .busy_o(busy[2]), .drop_o(drp[2]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: vector membership and the exact mathematical total
  int          cfg_aw[3] = '{40, 32, 32};
  bit          cfg_sat[3] = '{1'b1, 1'b1, 1'b0};
  bit          m_active;
  int          m_len, m_cnt;
  longint unsigned m_total;
  logic [63:0] e_sum[3];
  bit          e_ovf[3];
  bit          e_vo, e_drop;

  task automatic finish_vec();
    longint unsigned mx;
    for (int k = 0; k < 3; k++) begin
      mx = (64'd1 << cfg_aw[k]) - 64'd1;
      e_ovf[k] = (m_total > mx);
      if (cfg_sat[k]) e_sum[k] = (m_total > mx) ? mx : m_total;
      else            e_sum[k] = m_total & mx;
    end
    e_vo     = 1'b1;
    m_active = 1'b0;
  endtask

  task automatic model(input bit r, input bit s, input int vl, input longint unsigned p, input bit v);
    e_vo   = 1'b0;
    e_drop = 1'b0;
    if (r) begin
      m_active = 1'b0;
      for (int k = 0; k < 3; k++) begin e_sum[k] = 0; e_ovf[k] = 1'b0; end
    end else if (s) begin
      if (vl == 0) begin
        m_active = 1'b0;
        for (int k = 0; k < 3; k++) begin e_sum[k] = 0; e_ovf[k] = 1'b0; end
        e_vo   = 1'b1;
        e_drop = v;
      end else begin
        m_active = 1'b1;
        m_len    = vl;
        m_cnt    = v ? 1 : 0;
        m_total  = v ? p : 0;
        if (m_cnt == m_len) finish_vec();
      end
    end else if (v) begin
      if (m_active) begin
        m_total += p;
        m_cnt++;
        if (m_cnt == m_len) finish_vec();
      end else begin
        e_drop = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("sum40",  {24'd0, sum40},  e_sum[0]);
    chk("sum32s", {32'd0, sum32s}, e_sum[1]);
    chk("sum32w", {32'd0, sum32w}, e_sum[2]);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("overflow%0d", k),  {63'd0, ovf[k]},  {63'd0, e_ovf[k]});
      chk($sformatf("valid_out%0d", k), {63'd0, vo[k]},   {63'd0, e_vo});
      chk($sformatf("busy%0d", k),      {63'd0, busy[k]}, {63'd0, m_active});
      chk($sformatf("drop%0d", k),      {63'd0, drp[k]},  {63'd0, e_drop});
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [7:0] vl, input logic [31:0] p, input bit v);
    rst = r; start = s; vec_len = vl; product = p; valid_in = v;
    @(posedge clk);
    model(r, s, int'(vl), longint'(p), v);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
  endtask

  localparam logic [31:0] BIG = 32'hFFFE0001;

  initial begin
    rst = 1'b1; start = 1'b0; vec_len = 8'd0; product = 32'd0; valid_in = 1'b0;
    step(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    chk("reset_sum", {24'd0, sum40}, 64'd0);
    idle(1);

    // basic sum
    step(1'b0, 1'b1, 8'd4, 32'd0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 8'd0, 32'(i), 1'b1);
    chk("basic_sum", {24'd0, sum40}, 64'd10);
    idle(2);

    // gapped input
    step(1'b0, 1'b1, 8'd3, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(i * 2 + (i == 2 ? 1 : 0));
      step(1'b0, 1'b0, 8'd0, BIG, 1'b1);
    end
    chk("gapped_sum", {24'd0, sum40}, 64'h2_FFFA_0003);
    idle(2);

    // overflow, then a clean vector
    step(1'b0, 1'b1, 8'd2, BIG, 1'b1);
    step(1'b0, 1'b0, 8'd0, BIG, 1'b1);
    chk("sat_sum", {32'd0, sum32s}, 64'hFFFF_FFFF);
    chk("wrap_sum", {32'd0, sum32w}, 64'hFFFC_0002);
    chk("wrap_ovf", {63'd0, ovf[2]}, 64'd1);
    step(1'b0, 1'b1, 8'd2, 32'd3, 1'b1);
    step(1'b0, 1'b0, 8'd0, 32'd4, 1'b1);
    chk("clean_ovf", {63'd0, ovf[1]}, 64'd0);
    idle(1);

    // restart mid-vector
    step(1'b0, 1'b1, 8'd4, 32'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 32'd7, 1'b1);
    step(1'b0, 1'b0, 8'd0, 32'd9, 1'b1);
    step(1'b0, 1'b1, 8'd2, 32'd5, 1'b1);
    step(1'b0, 1'b0, 8'd0, 32'd6, 1'b1);
    chk("restart_sum", {24'd0, sum40}, 64'd11);
    idle(2);

    // edge cases
    step(1'b0, 1'b1, 8'd0, 32'd0, 1'b0);
    chk("len0_vo", {63'd0, vo[0]}, 64'd1);
    step(1'b0, 1'b0, 8'd0, 32'd99, 1'b1);
    chk("idle_drop", {63'd0, drp[0]}, 64'd1);
    idle(1);
    step(1'b0, 1'b1, 8'd1, 32'h4000_0000, 1'b1);
    chk("len1_sum", {24'd0, sum40}, 64'h4000_0000);
    idle(1);

    // reset mid-vector
    step(1'b0, 1'b1, 8'd4, 32'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 32'd8, 1'b1);
    step(1'b0, 1'b0, 8'd0, 32'd8, 1'b1);
    step(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    chk("rst_busy", {63'd0, busy[0]}, 64'd0);
    step(1'b0, 1'b1, 8'd2, 32'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 32'd2, 1'b1);
    step(1'b0, 1'b0, 8'd0, 32'd3, 1'b1);
    chk("post_rst_sum", {24'd0, sum40}, 64'd5);
    idle(1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit          r, s, v;
      logic [7:0]  vl;
      logic [31:0] p;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 19) == 0);
      vl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0:       p = BIG;
        1:       p = 32'($urandom_range(0, 15));
        default: p = $urandom;
      endcase
      v = ($urandom_range(0, 3) != 0);
      step(r, s, vl, p, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
